// File: rtl/axilapb.sv
`default_nettype none
// ============================================================================
// Module   : axilapb
// Purpose  : AXI4-Lite slave to APB master bridge, single clock domain.
//            One APB transfer outstanding at a time; when a write (AW+W) and
//            a read (AR) are both pending, grants alternate, read first
//            after reset.
// Ports    : S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//            S_AXI_AW* / W* / B*         AXI4-Lite write channels
//            S_AXI_AR* / R*              AXI4-Lite read channels
//            M_APB_*                     APB master (PSEL/PENABLE/PREADY ...)
// Revision : 1.0 - initial release
// ============================================================================
module axilapb #(
    parameter int C_AXI_ADDR_WIDTH = 12,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          M_APB_PSEL,
    output logic                          M_APB_PENABLE,
    input  logic                          M_APB_PREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_APB_PADDR,
    output logic                          M_APB_PWRITE,
    output logic [2:0]                    M_APB_PPROT,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PWDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_APB_PWSTRB,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PRDATA,
    input  logic                          M_APB_PSLVERR
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = C_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic          last_wr_q, last_wr_d;

    logic          aw_full_q, aw_full_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [2:0]    aw_prot_q, aw_prot_d;
    logic          w_full_q,  w_full_d;
    logic [DW-1:0] w_data_q,  w_data_d;
    logic [SW-1:0] w_strb_q,  w_strb_d;
    logic          ar_full_q, ar_full_d;
    logic [AW-1:0] ar_addr_q, ar_addr_d;
    logic [2:0]    ar_prot_q, ar_prot_d;

    logic          awready_q, awready_d;
    logic          wready_q,  wready_d;
    logic          arready_q, arready_d;

    logic          psel_q,    psel_d;
    logic          penable_q, penable_d;
    logic [AW-1:0] paddr_q,   paddr_d;
    logic          pwrite_q,  pwrite_d;
    logic [2:0]    pprot_q,   pprot_d;
    logic [DW-1:0] pwdata_q,  pwdata_d;
    logic [SW-1:0] pwstrb_q,  pwstrb_d;

    logic          bvalid_q,  bvalid_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic          rvalid_q,  rvalid_d;
    logic [1:0]    rresp_q,   rresp_d;
    logic [DW-1:0] rdata_q,   rdata_d;

    logic          wr_pend;
    logic          rd_pend;
    logic          grant_wr;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        aw_prot_d = aw_prot_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_full_d = ar_full_q;
        ar_addr_d = ar_addr_q;
        ar_prot_d = ar_prot_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pprot_d   = pprot_q;
        pwdata_d  = pwdata_q;
        pwstrb_d  = pwstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        wr_pend   = 1'b0;
        rd_pend   = 1'b0;
        grant_wr  = 1'b0;

        // Holding registers capture independently of the FSM.
        if (S_AXI_AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
            aw_prot_d = S_AXI_AWPROT;
        end
        if (S_AXI_WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (S_AXI_ARVALID && arready_q) begin
            ar_full_d = 1'b1;
            ar_addr_d = S_AXI_ARADDR;
            ar_prot_d = S_AXI_ARPROT;
        end

        case (state_q)
            S_IDLE: begin
                // Arbitrate on the post-capture view so a request accepted
                // this cycle is granted immediately (PSEL the next cycle).
                wr_pend  = aw_full_d && w_full_d;
                rd_pend  = ar_full_d;
                grant_wr = wr_pend && (!rd_pend || !last_wr_q);
                if (grant_wr) begin
                    paddr_d   = aw_addr_d;
                    pprot_d   = aw_prot_d;
                    pwrite_d  = 1'b1;
                    pwdata_d  = w_data_d;
                    pwstrb_d  = w_strb_d;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    last_wr_d = 1'b1;
                    psel_d    = 1'b1;
                    state_d   = S_SETUP;
                end else if (rd_pend) begin
                    paddr_d   = ar_addr_d;
                    pprot_d   = ar_prot_d;
                    pwrite_d  = 1'b0;
                    pwstrb_d  = '0;
                    ar_full_d = 1'b0;
                    last_wr_d = 1'b0;
                    psel_d    = 1'b1;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (M_APB_PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = {M_APB_PSLVERR, 1'b0};
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = {M_APB_PSLVERR, 1'b0};
                        rdata_d  = M_APB_PRDATA;
                    end
                    state_d = S_RESP;
                end
            end
            default: begin // S_RESP
                if (bvalid_q && S_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
                if (rvalid_q && S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                    state_d  = S_IDLE;
                end
            end
        endcase

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b1;  // makes the first contested grant a read
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pprot_q   <= '0;
            pwdata_q  <= '0;
            pwstrb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            aw_prot_q <= aw_prot_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_full_q <= ar_full_d;
            ar_addr_q <= ar_addr_d;
            ar_prot_q <= ar_prot_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pprot_q   <= pprot_d;
            pwdata_q  <= pwdata_d;
            pwstrb_q  <= pwstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign M_APB_PSEL    = psel_q;
    assign M_APB_PENABLE = penable_q;
    assign M_APB_PADDR   = paddr_q;
    assign M_APB_PWRITE  = pwrite_q;
    assign M_APB_PPROT   = pprot_q;
    assign M_APB_PWDATA  = pwdata_q;
    assign M_APB_PWSTRB  = pwstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_axilapb.sv
`default_nettype none
// ============================================================================
// Module   : tb_axilapb
// Purpose  : Self-checking bench for axilapb. Directed AXI stimulus, a small
//            APB slave with programmable wait states, and a transaction-level
//            model (expected APB transfer order, response contents, APB
//            phase rules) checked every cycle, plus literal latency checks.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axilapb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
    logic [11:0] awaddr = 0, araddr = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        psel, penable, pwrite;
    logic        pready = 1'b1;
    logic [11:0] paddr;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err = 1'b0;
    int          slv_wait = 0;
    int          acc_cnt = 0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axilapb #(.C_AXI_ADDR_WIDTH(12), .C_AXI_DATA_WIDTH(32)) dut (
        .S_AXI_ACLK(clk),         .S_AXI_ARESETN(rst_n),
        .S_AXI_AWVALID(awvalid),  .S_AXI_AWREADY(awready),
        .S_AXI_AWADDR(awaddr),    .S_AXI_AWPROT(awprot),
        .S_AXI_WVALID(wvalid),    .S_AXI_WREADY(wready),
        .S_AXI_WDATA(wdata),      .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid),    .S_AXI_BREADY(bready),
        .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid),  .S_AXI_ARREADY(arready),
        .S_AXI_ARADDR(araddr),    .S_AXI_ARPROT(arprot),
        .S_AXI_RVALID(rvalid),    .S_AXI_RREADY(rready),
        .S_AXI_RDATA(rdata),      .S_AXI_RRESP(rresp),
        .M_APB_PSEL(psel),        .M_APB_PENABLE(penable),
        .M_APB_PREADY(pready),    .M_APB_PADDR(paddr),
        .M_APB_PWRITE(pwrite),    .M_APB_PPROT(pprot),
        .M_APB_PWDATA(pwdata),    .M_APB_PWSTRB(pwstrb),
        .M_APB_PRDATA(slv_rdata), .M_APB_PSLVERR(slv_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // APB slave: PREADY outside ACCESS is held high to prove it is ignored.
    always @(posedge clk) begin
        #1;
        if (psel && penable) begin
            pready = (acc_cnt >= slv_wait);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'b1;
        end
    end

    // ---------------- transaction-level model ------------------------------
    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t cur;
    logic [51:0] snap;
    logic        m_setup_prev = 0, m_resp_wait = 0, m_resp_drop = 0;
    logic        m_exp_wr = 0, m_drop_rd = 0;
    logic [31:0] m_exp_rdata = 0;
    logic [1:0]  m_exp_resp = 0;
    int          m_hs_cyc = -100;

    task automatic push_x(input logic [11:0] a, input logic wr, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
        xfer_t x;
        x.addr = a; x.wr = wr; x.data = d; x.strb = wr ? s : 4'h0; x.prot = p;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_setup_prev = 0;
            m_resp_wait  = 0;
            m_resp_drop  = 0;
        end else begin
            if (penable && !psel) chk("penable_without_psel", 1, 0);
            if (psel && (bvalid || rvalid)) chk("apb_during_resp", 1, 0);
            if (m_setup_prev) chk("setup_one_cycle", {psel, penable}, 2'b11);
            if (psel && !penable) begin
                chk("resp_to_psel_gap_ok", (cyc - m_hs_cyc) >= 2, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("paddr", paddr, cur.addr);
                    chk("pwrite", pwrite, cur.wr);
                    chk("pprot", pprot, cur.prot);
                    chk("pwstrb", pwstrb, cur.strb);
                    if (cur.wr) chk("pwdata", pwdata, cur.data);
                end
                snap = {paddr, pwrite, pprot, pwdata, pwstrb};
            end
            if (psel && penable) chk("apb_stable", {paddr, pwrite, pprot, pwdata, pwstrb}, snap);
            if (m_resp_drop) begin
                chk("valid_drop", {bvalid, rvalid}, 2'b00);
                if (m_drop_rd) chk("rdata_cleared", rdata, 0);
                m_resp_drop = 0;
            end
            if (m_resp_wait) begin
                if (m_exp_wr) begin
                    chk("bvalid", {bvalid, rvalid}, 2'b10);
                    chk("bresp", bresp, m_exp_resp);
                end else begin
                    chk("rvalid", {bvalid, rvalid}, 2'b01);
                    chk("rresp", rresp, m_exp_resp);
                    chk("rdata", rdata, m_exp_rdata);
                end
                if ((bvalid && bready) || (rvalid && rready)) begin
                    m_resp_wait = 0;
                    m_resp_drop = 1;
                    m_drop_rd   = !m_exp_wr;
                    m_hs_cyc    = cyc;
                end
            end
            if (psel && penable && pready) begin
                m_resp_wait = 1;
                m_exp_wr    = cur.wr;
                m_exp_rdata = slv_rdata;
                m_exp_resp  = {slv_err, 1'b0};
            end
            m_setup_prev = psel && !penable;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    // Returns at 1 time unit after the edge that completed the last handshake.
    task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [11:0] awa, input logic [2:0] awp,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [11:0] ara, input logic [2:0] arp);
        bit aw_p, w_p, ar_p, aw_r, w_r, ar_r;
        aw_p = do_aw; w_p = do_w; ar_p = do_ar;
        awaddr = awa; awprot = awp; wdata = wd; wstrb = ws; araddr = ara; arprot = arp;
        awvalid = aw_p; wvalid = w_p; arvalid = ar_p;
        for (int i = 0; i < 40 && (aw_p || w_p || ar_p); i++) begin
            aw_r = awready; w_r = wready; ar_r = arready;
            tick();
            if (aw_r) aw_p = 0;
            if (w_r)  w_p  = 0;
            if (ar_r) ar_p = 0;
            awvalid = aw_p; wvalid = w_p; arvalid = ar_p;
        end
        if (aw_p || w_p || ar_p) begin
            fail_now("axi_handshake");
            awvalid = 0; wvalid = 0; arvalid = 0;
        end
    endtask

    task automatic wait_resp();
        bit done;
        done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            if ((bvalid && bready) || (rvalid && rready)) done = 1;
            tick();
        end
        if (!done) fail_now("response");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------------------------------
    initial begin
        int pen_cnt, k;
        bit seen;

        // Reset state
        repeat (3) tick();
        chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid, psel, penable}, 0);
        chk("reset_data", {paddr, pwdata, pwstrb, pprot, pwrite, rdata, bresp, rresp}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        // 1: single write, AW and W together, no wait states
        push_x(12'h010, 1, 32'hDEADBEEF, 4'hF, 3'b001);
        send(1, 1, 0, 12'h010, 3'b001, 32'hDEADBEEF, 4'hF, 12'h0, 3'b0);
        chk("t1_psel_n1", {psel, penable, pwrite}, 3'b101);
        chk("t1_paddr", paddr, 12'h010);
        tick();
        chk("t1_penable_n2", {psel, penable}, 2'b11);
        tick();
        chk("t1_bvalid_n3", {bvalid, bresp, psel}, 4'b1000);
        tick();
        chk("t1_bvalid_drop", bvalid, 0);

        // 2: read, 3 wait states, PSLVERR, RREADY held low 4 cycles
        rready = 0; slv_wait = 3; slv_rdata = 32'h12345678; slv_err = 1;
        push_x(12'h024, 0, 32'h0, 4'h0, 3'b010);
        send(0, 0, 1, 12'h0, 3'b0, 32'h0, 4'h0, 12'h024, 3'b010);
        pen_cnt = 0; seen = 0; k = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (rvalid) begin seen = 1; k = i; end
            else begin
                if (penable) pen_cnt++;
                tick();
            end
        end
        if (!seen) fail_now("t2_rvalid");
        chk("t2_penable_cycles", pen_cnt, 4);
        chk("t2_rvalid_latency", k, 5);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rhold", {rvalid, rresp, rdata}, {1'b1, 2'b10, 32'h12345678});
            tick();
        end
        rready = 1;
        tick();
        chk("t2_rdata_zero", {rvalid, rdata}, 0);
        slv_wait = 0; slv_err = 0;

        // 3: W five cycles before AW
        send(0, 1, 0, 12'h0, 3'b0, 32'hA5A50001, 4'h3, 12'h0, 3'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_wait_aw", {psel, wready, awready}, 3'b001);
            tick();
        end
        push_x(12'h0FC, 1, 32'hA5A50001, 4'h3, 3'b000);
        send(1, 0, 0, 12'h0FC, 3'b000, 32'h0, 4'h0, 12'h0, 3'b0);
        chk("t3_psel_after_aw", psel, 1);
        wait_resp();

        // 4: contested grants alternate, read first (last grant was a write)
        for (int i = 0; i < 4; i++) begin
            slv_err   = (i == 2);
            slv_rdata = 32'h10000000 + 32'(i);
            push_x(12'h100 + 12'(i * 16), 0, 32'h0, 4'h0, 3'b000);
            push_x(12'h800 + 12'(i * 4), 1, 32'hA0000000 + 32'(i), 4'hF >> i, 3'b010);
            send(1, 1, 1, 12'h800 + 12'(i * 4), 3'b010, 32'hA0000000 + 32'(i),
                 4'hF >> i, 12'h100 + 12'(i * 16), 3'b000);
            chk("t4_first_is_read", {psel, pwrite}, 2'b10);
            wait_resp();
            wait_resp();
        end
        slv_err = 0;

        // 5: reset during ACCESS, with a lone AW held (must be discarded)
        slv_wait = 20;
        push_x(12'h200, 0, 32'h0, 4'h0, 3'b000);
        send(0, 0, 1, 12'h0, 3'b0, 32'h0, 4'h0, 12'h200, 3'b000);
        send(1, 0, 0, 12'h0AA, 3'b000, 32'h0, 4'h0, 12'h0, 3'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (psel && penable) seen = 1; else tick();
        end
        if (!seen) fail_now("t5_access");
        tick(); tick();
        rst_n = 0;
        #1;
        chk("t5_reset_immediate", {psel, penable, awready, wready, arready, bvalid, rvalid}, 0);
        tick(); tick();
        rst_n = 1;
        slv_wait = 0; slv_rdata = 32'hCAFEF00D;
        push_x(12'h3F0, 0, 32'h0, 4'h0, 3'b100);
        send(0, 0, 1, 12'h0, 3'b0, 32'h0, 4'h0, 12'h3F0, 3'b100);
        chk("t5_read_after_reset", {psel, paddr}, {1'b1, 12'h3F0});
        wait_resp();
        send(0, 1, 0, 12'h0, 3'b0, 32'h5555AAAA, 4'h1, 12'h0, 3'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_aw_discarded", psel, 0);
            tick();
        end
        push_x(12'h044, 1, 32'h5555AAAA, 4'h1, 3'b000);
        send(1, 0, 0, 12'h044, 3'b000, 32'h0, 4'h0, 12'h0, 3'b0);
        wait_resp();

        // 6: back-to-back reads, next PSEL exactly two cycles after handshake
        slv_rdata = 32'h0BADF00D;
        push_x(12'h300, 0, 32'h0, 4'h0, 3'b000);
        push_x(12'h304, 0, 32'h0, 4'h0, 3'b000);
        send(0, 0, 1, 12'h0, 3'b0, 32'h0, 4'h0, 12'h300, 3'b000);
        send(0, 0, 1, 12'h0, 3'b0, 32'h0, 4'h0, 12'h304, 3'b000);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (rvalid) seen = 1; else tick();
        end
        if (!seen) fail_now("t6_rvalid");
        tick();
        chk("t6_no_psel_m1", psel, 0);
        tick();
        chk("t6_psel_m2", {psel, paddr}, {1'b1, 12'h304});
        wait_resp();
        repeat (3) tick();
        chk("t6_all_consumed", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
